// File: rtl/m68k_bus_pkg.sv
// Shared types and widths for the 68000-to-async-SRAM bridge.
// Bus state encoding and address/data window widths.
package m68k_bus_pkg;
  localparam int SRAM_AW = 20;
  localparam int DW      = 16;
  localparam int CPU_AW  = 23;
  localparam int WIN_W   = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;
endpackage

// File: rtl/sram_ws_counter.sv
// Loadable 4-bit down-counter that times the SRAM access phase.
// last flags the final wait-state cycle.
module sram_ws_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       last
);
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign last = (cnt == 4'd1);
endmodule

// File: rtl/m68k_sram_ctrl.sv
// 68000 asynchronous bus to 1Mx16 async SRAM bridge with programmable wait states.
// SRAM strobes are decoded from the registered state only, so reset clears them asynchronously.
module m68k_sram_ctrl
  import m68k_bus_pkg::*;
#(
  parameter logic [WIN_W-1:0] BASE_A23_21 = 3'b000,
  parameter int               WAIT_STATES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CPU_AW:1]    cpu_addr,
  input  logic               cpu_as_n,
  input  logic               cpu_uds_n,
  input  logic               cpu_lds_n,
  input  logic               cpu_rw,
  input  logic [DW-1:0]      cpu_wdata,
  output logic [DW-1:0]      cpu_rdata,
  output logic               cpu_dtack_n,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DW-1:0]      sram_wdata,
  input  logic [DW-1:0]      sram_rdata,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n,
  output state_t             dbg_state
);
  state_t             state, state_nxt;
  logic [SRAM_AW-1:0] addr_q;
  logic [DW-1:0]      wdata_q;
  logic               rw_q, ub_q, lb_q;
  logic               hit, last;

  assign hit = !cpu_as_n && (!cpu_uds_n || !cpu_lds_n) &&
               (cpu_addr[CPU_AW:CPU_AW-WIN_W+1] == BASE_A23_21);

  sram_ws_counter u_ws (
    .clk      (clk),
    .rst      (rst),
    .load     (state == SETUP),
    .dec      (state == ACCESS),
    .load_val (4'(WAIT_STATES)),
    .last     (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // AS_n rising anywhere past IDLE ends the cycle; DONE waits for it to release DTACK.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hit) state_nxt = SETUP;
      SETUP:   state_nxt = cpu_as_n ? IDLE : ACCESS;
      ACCESS:  if (cpu_as_n) state_nxt = IDLE;
               else if (last) state_nxt = HOLD;
      HOLD:    state_nxt = cpu_as_n ? IDLE : DONE;
      DONE:    if (cpu_as_n) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture only from IDLE so address, data and lanes stay frozen until the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b1;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
    end else if (state == IDLE && hit) begin
      addr_q  <= cpu_addr[SRAM_AW:1];
      wdata_q <= cpu_wdata;
      rw_q    <= cpu_rw;
      ub_q    <= cpu_uds_n;
      lb_q    <= cpu_lds_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata <= '0;
    end else if (state == ACCESS && !cpu_as_n && last && rw_q) begin
      cpu_rdata <= sram_rdata;
    end
  end

  assign sram_addr   = addr_q;
  assign sram_wdata  = wdata_q;
  assign sram_ce_n   = (state == IDLE);
  assign sram_oe_n   = !(rw_q && (state == SETUP || state == ACCESS || state == HOLD));
  assign sram_we_n   = !(!rw_q && state == ACCESS);
  assign sram_ub_n   = (state == IDLE) ? 1'b1 : ub_q;
  assign sram_lb_n   = (state == IDLE) ? 1'b1 : lb_q;
  assign cpu_dtack_n = (state != DONE);
  assign dbg_state   = state;
endmodule
